// File: rtl/spi_slave_gen_if.sv
// Serial-side and memory-side signal bundle for spi_slave_gen; slave modport faces the DUT.
// Signal names follow the slave's external pin names; rx_data is DATA_W+2 wide (command + payload).
interface spi_slave_gen_if #(
  parameter int DATA_W = 8
);
  logic              SS_n;
  logic              MOSI;
  logic              MISO;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              rx_valid;
  logic [DATA_W+1:0] rx_data;
  logic              busy;
  logic              frame_err;

  modport slave (
    input  SS_n, MOSI, tx_valid, tx_data,
    output MISO, rx_valid, rx_data, busy, frame_err
  );

  modport master (
    output SS_n, MOSI, tx_valid, tx_data,
    input  MISO, rx_valid, rx_data, busy, frame_err
  );
endinterface

// File: rtl/spi_slave_gen.sv
// Clk-sampled SPI slave: 2-bit command + DATA_W payload per frame, rx_valid the cycle after the last bit, read data shifted on MISO.
// No backpressure; SS_n high aborts/ends a frame. Define SPI_SLV_FRAME_ERR_EN for the frame_err abort pulse.
module spi_slave_gen #(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_slave_gen_if.slave bus
);
  localparam int FRAME_W = DATA_W + 2;
  localparam int CW      = $clog2(FRAME_W + 1);
  localparam int TW      = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [FRAME_W-1:0] r_sh;
  logic [FRAME_W-1:0] r_rx_data;
  logic               r_rx_valid;
  logic               r_rd_pend;
  logic               r_miso;
  logic               r_tx_act;
  logic               r_tx_done;
  logic [DATA_W-1:0]  r_tx;
  logic [TW-1:0]      r_tx_cnt;

  logic [CW-1:0]      w_pos;
  logic [FRAME_W-1:0] w_asm;
  logic               w_cap;
  logic               w_last;
  logic               w_win;

  // Command bits always land at the top; only the payload honours LSB-first order.
  assign w_pos  = (MSB_FIRST || (r_cnt < CW'(2))) ? (CW'(FRAME_W - 1) - r_cnt) : (r_cnt - CW'(2));
  assign w_cap  = (r_state != IDLE) && !bus.SS_n && (r_cnt < CW'(FRAME_W));
  assign w_last = (r_cnt == CW'(FRAME_W - 1));
  assign w_win  = (r_state == READ_DATA) && (r_cnt == CW'(FRAME_W)) && !r_tx_done && !r_tx_act;

  always_comb begin
    w_asm = r_sh;
    for (int i = 0; i < FRAME_W; i++) begin
      if (CW'(i) == w_pos) w_asm[i] = bus.MOSI;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sh       <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_rd_pend  <= 1'b0;
      r_miso     <= 1'b0;
      r_tx_act   <= 1'b0;
      r_tx_done  <= 1'b0;
      r_tx       <= '0;
      r_tx_cnt   <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      if (r_state == IDLE || bus.SS_n) begin
        r_cnt     <= '0;
        r_miso    <= 1'b0;
        r_tx_act  <= 1'b0;
        r_tx_done <= 1'b0;
        r_tx_cnt  <= '0;
        r_state   <= (r_state == IDLE && !bus.SS_n) ? CHK_CMD : IDLE;
      end else begin
        if (w_cap) begin
          r_sh  <= w_asm;
          r_cnt <= r_cnt + CW'(1);
          if (r_state == CHK_CMD) begin
            r_state <= !bus.MOSI ? WRITE : (r_rd_pend ? READ_DATA : READ_ADD);
          end
          if (w_last) begin
            r_rx_data  <= w_asm;
            r_rx_valid <= 1'b1;
            if (r_state == READ_ADD)       r_rd_pend <= 1'b1;
            else if (r_state == READ_DATA) r_rd_pend <= 1'b0;
          end
        end
        // One load per READ_DATA frame; the first bit goes out on the load edge.
        if (r_tx_act) begin
          r_tx_cnt <= r_tx_cnt - TW'(1);
          if (r_tx_cnt == TW'(1)) begin
            r_tx_act <= 1'b0;
            r_miso   <= 1'b0;
          end else if (MSB_FIRST) begin
            r_miso <= r_tx[DATA_W-1];
            r_tx   <= r_tx << 1;
          end else begin
            r_miso <= r_tx[0];
            r_tx   <= r_tx >> 1;
          end
        end else if (w_win && bus.tx_valid) begin
          r_tx_act  <= 1'b1;
          r_tx_done <= 1'b1;
          r_tx_cnt  <= TW'(DATA_W);
          r_miso    <= MSB_FIRST ? bus.tx_data[DATA_W-1] : bus.tx_data[0];
          r_tx      <= MSB_FIRST ? (bus.tx_data << 1) : (bus.tx_data >> 1);
        end
      end
    end
  end

`ifdef SPI_SLV_FRAME_ERR_EN
  logic r_frame_err;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_frame_err <= 1'b0;
    else        r_frame_err <= (r_state != IDLE) && bus.SS_n && (r_cnt < CW'(FRAME_W));
  end
  assign bus.frame_err = r_frame_err;
`else
  assign bus.frame_err = 1'b0;
`endif

  assign bus.MISO     = r_miso;
  assign bus.rx_valid = r_rx_valid;
  assign bus.rx_data  = r_rx_data;
  assign bus.busy     = (r_state != IDLE);
endmodule

// File: tb/tb_spi_slave_gen.sv
// Directed bench for spi_slave_gen: DATA_W=8 MSB-first and DATA_W=12 LSB-first instances on one clock.
`timescale 1ns/1ps
module tb_spi_slave_gen;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spi_slave_gen_if #(.DATA_W(8))  b8 ();
  spi_slave_gen_if #(.DATA_W(12)) b12 ();

  spi_slave_gen #(.DATA_W(8), .MSB_FIRST(1'b1)) u8 (.clk(clk), .rst_n(rst_n), .bus(b8));
  spi_slave_gen #(.DATA_W(12), .MSB_FIRST(1'b0)) u12 (.clk(clk), .rst_n(rst_n), .bus(b12));

`ifdef SPI_SLV_FRAME_ERR_EN
  localparam logic FERR = 1'b1;
`else
  localparam logic FERR = 1'b0;
`endif

  int   errs = 0;
  int   checks = 0;
  int   vcnt;
  logic miso_or;
  logic [7:0]  got8;
  logic [11:0] got12;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int w, input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (w == 8) b8.MOSI = bits[5'(n-1-i)];
      else        b12.MOSI = bits[5'(n-1-i)];
      tick();
      if (w == 8) begin
        vcnt += int'(b8.rx_valid);
        miso_or |= b8.MISO;
      end else begin
        vcnt += int'(b12.rx_valid);
        miso_or |= b12.MISO;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    b8.SS_n = 1'b1;  b8.MOSI = 1'b0;  b8.tx_valid = 1'b0;  b8.tx_data = '0;
    b12.SS_n = 1'b1; b12.MOSI = 1'b0; b12.tx_valid = 1'b0; b12.tx_data = '0;
    #12;
    checks++; if (b8.busy !== 1'b0) begin errs++; $display("FAIL reset_busy got=%b exp=0", b8.busy); end
    checks++; if (b8.rx_valid !== 1'b0) begin errs++; $display("FAIL reset_rx_valid got=%b exp=0", b8.rx_valid); end
    checks++; if (b8.rx_data !== 10'h000) begin errs++; $display("FAIL reset_rx_data got=%h exp=000", b8.rx_data); end
    checks++; if (b8.MISO !== 1'b0) begin errs++; $display("FAIL reset_miso got=%b exp=0", b8.MISO); end
    checks++; if (b8.frame_err !== 1'b0) begin errs++; $display("FAIL reset_frame_err got=%b exp=0", b8.frame_err); end
    checks++; if (b12.rx_data !== 14'h0000) begin errs++; $display("FAIL reset_rx_data12 got=%h exp=0000", b12.rx_data); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write();
    b8.tx_valid = 1'b1; b8.tx_data = 8'hFF;
    b8.SS_n = 1'b0; vcnt = 0; miso_or = 1'b0;
    tick();
    checks++; if (b8.busy !== 1'b1) begin errs++; $display("FAIL write_busy got=%b exp=1", b8.busy); end
    drive(8, 32'h0A5, 10);
    checks++; if (b8.rx_valid !== 1'b1 || vcnt != 1) begin errs++; $display("FAIL write_valid got=%b/%0d exp=1/1", b8.rx_valid, vcnt); end
    checks++; if (b8.rx_data !== 10'h0A5) begin errs++; $display("FAIL write_data got=%h exp=0a5", b8.rx_data); end
    drive(8, 32'h7, 3);
    checks++; if (vcnt != 1 || b8.rx_data !== 10'h0A5) begin errs++; $display("FAIL write_extra got=%0d/%h exp=1/0a5", vcnt, b8.rx_data); end
    checks++; if (miso_or !== 1'b0) begin errs++; $display("FAIL write_miso got=%b exp=0", miso_or); end
    b8.SS_n = 1'b1;
    tick();
    checks++; if (b8.busy !== 1'b0) begin errs++; $display("FAIL write_idle got=%b exp=0", b8.busy); end
    checks++; if (b8.frame_err !== 1'b0) begin errs++; $display("FAIL write_no_err got=%b exp=0", b8.frame_err); end
    b8.tx_valid = 1'b0;
  endtask

  task automatic test_read();
    b8.SS_n = 1'b0; tick(); vcnt = 0;
    drive(8, 32'h203, 10);
    checks++; if (b8.rx_data !== 10'h203 || vcnt != 1) begin errs++; $display("FAIL rd_addr got=%h/%0d exp=203/1", b8.rx_data, vcnt); end
    b8.SS_n = 1'b1; tick();
    b8.SS_n = 1'b0; tick();
    drive(8, 32'h35A, 10);
    checks++; if (b8.rx_valid !== 1'b1 || b8.rx_data !== 10'h35A) begin errs++; $display("FAIL rd_data_frame got=%b/%h exp=1/35a", b8.rx_valid, b8.rx_data); end
    b8.tx_valid = 1'b1; b8.tx_data = 8'hC6;
    tick();
    b8.tx_data = 8'h00;
    got8 = '0;
    for (int i = 0; i < 8; i++) begin
      got8 = {got8[6:0], b8.MISO};
      if (i < 7) tick();
    end
    checks++; if (got8 !== 8'hC6) begin errs++; $display("FAIL rd_miso got=%h exp=c6", got8); end
    miso_or = 1'b0;
    drive(8, 32'h0, 3);
    checks++; if (miso_or !== 1'b0) begin errs++; $display("FAIL rd_no_reload got=%b exp=0", miso_or); end
    b8.tx_valid = 1'b0; b8.SS_n = 1'b1; tick();
    // rd_pend must now be clear: a 1x frame is address-class and ignores tx_valid
    b8.SS_n = 1'b0; tick(); vcnt = 0;
    drive(8, 32'h2FF, 10);
    checks++; if (b8.rx_data !== 10'h2FF) begin errs++; $display("FAIL rd_pend_clear_frame got=%h exp=2ff", b8.rx_data); end
    b8.tx_valid = 1'b1; b8.tx_data = 8'hFF; miso_or = 1'b0;
    drive(8, 32'h0, 10);
    checks++; if (miso_or !== 1'b0) begin errs++; $display("FAIL rd_pend_clear_miso got=%b exp=0", miso_or); end
    b8.tx_valid = 1'b0; b8.SS_n = 1'b1; tick();
  endtask

  task automatic test_abort_and_reset_mid_shift();
    b8.SS_n = 1'b0; tick(); vcnt = 0;
    drive(8, 32'h1A, 5);
    b8.SS_n = 1'b1; tick();
    checks++; if (vcnt != 0 || b8.rx_valid !== 1'b0) begin errs++; $display("FAIL abort_valid got=%0d/%b exp=0/0", vcnt, b8.rx_valid); end
    checks++; if (b8.rx_data !== 10'h2FF) begin errs++; $display("FAIL abort_data got=%h exp=2ff", b8.rx_data); end
    checks++; if (b8.frame_err !== FERR) begin errs++; $display("FAIL abort_err got=%b exp=%b", b8.frame_err, FERR); end
    checks++; if (b8.busy !== 1'b0) begin errs++; $display("FAIL abort_idle got=%b exp=0", b8.busy); end
    tick();
    checks++; if (b8.frame_err !== 1'b0) begin errs++; $display("FAIL abort_err_pulse got=%b exp=0", b8.frame_err); end
    // rd_pend survived the abort, so this 11 frame is a data read
    b8.SS_n = 1'b0; tick();
    drive(8, 32'h3C3, 10);
    checks++; if (b8.rx_data !== 10'h3C3) begin errs++; $display("FAIL after_abort_data got=%h exp=3c3", b8.rx_data); end
    b8.tx_valid = 1'b1; b8.tx_data = 8'hFF;
    tick(); tick();
    checks++; if (b8.MISO !== 1'b1) begin errs++; $display("FAIL pend_kept_miso got=%b exp=1", b8.MISO); end
    rst_n = 1'b0;
    #1;
    checks++; if (b8.MISO !== 1'b0 || b8.busy !== 1'b0) begin errs++; $display("FAIL rst_mid_shift got=%b/%b exp=0/0", b8.MISO, b8.busy); end
    checks++; if (b8.rx_data !== 10'h000) begin errs++; $display("FAIL rst_mid_data got=%h exp=000", b8.rx_data); end
    b8.tx_valid = 1'b0; b8.SS_n = 1'b1;
    tick(); rst_n = 1'b1; tick();
    b8.SS_n = 1'b0; tick(); vcnt = 0;
    drive(8, 32'h300, 10);
    checks++; if (b8.rx_data !== 10'h300 || vcnt != 1) begin errs++; $display("FAIL post_rst_frame got=%h/%0d exp=300/1", b8.rx_data, vcnt); end
    b8.tx_valid = 1'b1; miso_or = 1'b0;
    drive(8, 32'h0, 10);
    checks++; if (miso_or !== 1'b0) begin errs++; $display("FAIL post_rst_read_add got=%b exp=0", miso_or); end
    b8.tx_valid = 1'b0; b8.SS_n = 1'b1; tick();
  endtask

  task automatic test_lsb_first();
    b12.SS_n = 1'b0; tick(); vcnt = 0;
    drive(12, 32'h1CA5, 14);
    checks++; if (b12.rx_valid !== 1'b1 || vcnt != 1) begin errs++; $display("FAIL lsb_valid got=%b/%0d exp=1/1", b12.rx_valid, vcnt); end
    checks++; if (b12.rx_data !== 14'h1A53) begin errs++; $display("FAIL lsb_data got=%h exp=1a53", b12.rx_data); end
    b12.SS_n = 1'b1; tick();
    b12.SS_n = 1'b0; tick();
    drive(12, 32'h2000, 14);
    checks++; if (b12.rx_data !== 14'h2000) begin errs++; $display("FAIL lsb_rd_addr got=%h exp=2000", b12.rx_data); end
    b12.SS_n = 1'b1; tick();
    b12.SS_n = 1'b0; tick();
    drive(12, 32'h3000, 14);
    b12.tx_valid = 1'b1; b12.tx_data = 12'h0F1;
    tick();
    b12.tx_valid = 1'b0;
    got12 = '0;
    for (int i = 0; i < 12; i++) begin
      got12 = {b12.MISO, got12[11:1]};
      if (i < 11) tick();
    end
    checks++; if (got12 !== 12'h0F1) begin errs++; $display("FAIL lsb_miso got=%h exp=0f1", got12); end
    tick();
    checks++; if (b12.MISO !== 1'b0) begin errs++; $display("FAIL lsb_miso_end got=%b exp=0", b12.MISO); end
    b12.SS_n = 1'b1; tick();
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_abort_and_reset_mid_shift();
    test_lsb_first();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
